// File: rtl/rf_wport_arbiter_pkg.sv
// Shared widths, register-file geometry and grant encoding for the
// register-file write-port arbiter.
package rf_wport_arbiter_pkg;

    localparam int REG_AW               = 5;
    localparam int REG_DW               = 32;
    localparam int NUM_REGS             = 32;
    localparam int STARVE_W             = 4;
    localparam int DEFAULT_STARVE_LIMIT = 4;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_PIPE,
        GNT_MDU
    } grant_e;

    // Register 0 is hardwired to zero: writes to it are dropped, never tracked.
    function automatic logic is_real_reg(input logic [REG_AW-1:0] addr);
        return addr != '0;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard for MDU destinations: issue sets a bit,
// MDU commit clears it, and hazard queries read the registered vector.
module rf_scoreboard
    import rf_wport_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              iss_valid,
    input  logic [REG_AW-1:0] iss_wa,
    output logic              iss_ready,
    input  logic              clr_en,
    input  logic [REG_AW-1:0] clr_wa,
    input  logic [REG_AW-1:0] ra1,
    input  logic [REG_AW-1:0] ra2,
    output logic              pend1,
    output logic              pend2
);

    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_d;
    logic                clr_hit;
    logic                set_en;

    // NOTE: blocking assignments in always_comb evaluate in order, so the set
    // below overrides the clear of the same bit, and defaults come first.
    always_comb begin
        clr_hit   = clr_en && (clr_wa == iss_wa);
        iss_ready = !rst && !(is_real_reg(iss_wa) && pending_q[iss_wa] && !clr_hit);
        set_en    = iss_valid && iss_ready && is_real_reg(iss_wa);

        pending_d = pending_q;
        if (clr_en) pending_d[clr_wa] = 1'b0;
        if (set_en) pending_d[iss_wa] = 1'b1;
        pending_d[0] = 1'b0;
    end

    // NOTE: state registers use non-blocking assignments; the pending vector is
    // a plain flop bank, so it is cleared by reset like any other control state.
    always_ff @(posedge clk) begin
        if (rst) pending_q <= '0;
        else     pending_q <= pending_d;
    end

    // No same-cycle bypass: a fresh issue shows up as pending one cycle later.
    assign pend1 = !rst && pending_q[ra1];
    assign pend2 = !rst && pending_q[ra2];

endmodule

// File: rtl/rf_wport_arbiter.sv
// Single register-file write port shared by pipeline writeback and a
// multi-cycle unit, with pipe priority bounded by an MDU starvation limit.
module rf_wport_arbiter
    import rf_wport_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pipe_we,
    input  logic [REG_AW-1:0] pipe_wa,
    input  logic [REG_DW-1:0] pipe_wd,
    output logic              pipe_stall,
    input  logic              mdu_valid,
    input  logic [REG_AW-1:0] mdu_wa,
    input  logic [REG_DW-1:0] mdu_wd,
    output logic              mdu_ready,
    input  logic              iss_valid,
    input  logic [REG_AW-1:0] iss_wa,
    output logic              iss_ready,
    input  logic [REG_AW-1:0] ra1,
    input  logic [REG_AW-1:0] ra2,
    output logic              pend1,
    output logic              pend2,
    output logic              we3,
    output logic [REG_AW-1:0] wa3,
    output logic [REG_DW-1:0] wd3
);

    localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

    logic [STARVE_W-1:0] starve_q;
    logic [STARVE_W-1:0] starve_d;
    logic                pipe_req;
    logic                mdu_req;
    logic                force_mdu;
    grant_e              grant;

    always_comb begin
        pipe_req  = pipe_we && is_real_reg(pipe_wa);
        mdu_req   = mdu_valid && is_real_reg(mdu_wa);
        force_mdu = mdu_req && (starve_q == LIMIT);

        grant = GNT_NONE;
        if (rst)            grant = GNT_NONE;
        else if (force_mdu) grant = GNT_MDU;
        else if (pipe_req)  grant = GNT_PIPE;
        else if (mdu_req)   grant = GNT_MDU;

        we3 = 1'b0;
        wa3 = '0;
        wd3 = '0;
        case (grant)
            GNT_PIPE: begin
                we3 = 1'b1;
                wa3 = pipe_wa;
                wd3 = pipe_wd;
            end
            GNT_MDU: begin
                we3 = 1'b1;
                wa3 = mdu_wa;
                wd3 = mdu_wd;
            end
            default: ;
        endcase

        pipe_stall = !rst && force_mdu && pipe_req;
        // Results aimed at register 0 are accepted and discarded.
        mdu_ready  = (grant == GNT_MDU) || (!rst && mdu_valid && !is_real_reg(mdu_wa));

        starve_d = '0;
        if (mdu_req && grant != GNT_MDU)
            starve_d = (starve_q >= LIMIT) ? LIMIT : starve_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) starve_q <= '0;
        else     starve_q <= starve_d;
    end

    rf_scoreboard u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .iss_valid (iss_valid),
        .iss_wa    (iss_wa),
        .iss_ready (iss_ready),
        .clr_en    (grant == GNT_MDU),
        .clr_wa    (mdu_wa),
        .ra1       (ra1),
        .ra2       (ra2),
        .pend1     (pend1),
        .pend2     (pend2)
    );

endmodule
